uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  Sequencer/buffer controller behind uart_rx: captures each completed frame (word + error flags),
//  pushes it into an RX FIFO, drives receiver back-pressure (i_fifo_full of uart_rx), and raises
//  data-ready / overrun / idle-timeout interrupts. Sits between uart_rx and the register block.
// PARAMETERS
//  FIFO_DEPTH   16   RX FIFO entries; power of 2, 2..256
//  CNT_W        $clog2(FIFO_DEPTH)+1   occupancy counter width (derived, not overridden)
// PORTS
//  i_clk              in   1      clock
//  i_nrst             in   1      async reset, active low
//  i_rx_started       in   1      uart_rx o_rx_started (level while in START)
//  i_rx_done          in   1      uart_rx o_rx_done (level while in FINISH)
//  i_rx_frame_error   in   1      uart_rx frame error, valid with i_rx_done
//  i_rx_parity_error  in   1      uart_rx parity error, valid with i_rx_done
//  i_rx_word          in   9      uart_rx word {parity, data[7:0]}
//  o_fifo_full        out  1      to uart_rx i_fifo_full (RTS back-pressure)
//  i_parity_enable    in   1      0: parity error flag forced 0 when stored
//  i_rts_level        in   CNT_W  occupancy at/above which o_fifo_full asserts
//  i_bit_length       in   32     clocks per bit (same value given to uart_rx)
//  i_timeout_bits     in   8      idle bit-times before timeout IRQ; 0 disables
//  i_rd_ack           in   1      pop head entry (honoured only when o_rd_valid)
//  o_rd_valid         out  1      FIFO not empty
//  o_rd_data          out  10     head entry {frame_err, parity_err, data[7:0]}, first-word fall-through
//  o_level            out  CNT_W  current occupancy
//  i_status_clr       in   1      clear sticky overrun and timeout flags
//  o_irq_data         out  1      = o_rd_valid
//  o_irq_overrun      out  1      sticky: frame dropped on full FIFO
//  o_irq_timeout      out  1      sticky: idle timeout with data pending
// BEHAVIOUR
//  Reset: FSM IDLE, FIFO empty, all counters 0, all outputs 0 (o_rd_data 0).
//  FSM: IDLE -> ACTIVE on i_rx_started; ACTIVE -> PUSH on rising edge of i_rx_done;
//   PUSH (1 cycle) -> GAP; GAP -> ACTIVE on i_rx_started, else stays GAP; GAP -> IDLE when FIFO empties.
//  i_rx_done is edge-detected (registered copy); exactly one push per frame regardless of level width.
//  Word/flags latched on the i_rx_done rising edge; written to FIFO in PUSH; visible on o_rd_valid next cycle.
//  Pop: i_rd_ack && o_rd_valid removes head same edge; i_rd_ack on empty ignored, no underflow.
//  Push+pop same cycle: both performed, occupancy unchanged; also when full (push accepted).
//  Push while full without pop: entry dropped, FIFO unchanged, o_irq_overrun set.
//  Pointers wrap modulo FIFO_DEPTH; occupancy saturates at FIFO_DEPTH by construction.
//  o_fifo_full registered: (occupancy >= i_rts_level) || occupancy == FIFO_DEPTH; i_rts_level 0 -> always 1.
//  Sticky flags: set wins over i_status_clr in the same cycle.
//  Reset mid-frame: everything returns to reset values; the partially received frame is lost.
// CONFIGURATION
//  UART_RX_TIMEOUT_EN defined: timeout logic present. In GAP with data pending, a prescaler counts
//   i_bit_length clocks per bit-time and a bit counter counts bit-times; reaching i_timeout_bits sets
//   o_irq_timeout. Both counters clear on i_rx_started, any pop, or leaving GAP; i_timeout_bits 0 disables.
//  UART_RX_TIMEOUT_EN undefined: no counters synthesised, o_irq_timeout tied 0, i_timeout_bits unused.
// STRUCTURE
//  uart_pkg gains: rx_ctrl_state_e enum {IDLE, ACTIVE, PUSH, GAP}; rx_fifo_entry_t packed struct
//   {frame_err, parity_err, data[7:0]}; RX_ENTRY_W = 10 constant.
//  Sub-module uart_sync_fifo (WIDTH, DEPTH params; push/pop/full/empty/level) holds storage and pointers;
//   FSM, edge detect, back-pressure, sticky flags, timeout live in uart_rx_ctrl.
// TESTING
//  Reset, then 3 frames 0x41,0x42,0x43 (1-cycle i_rx_done each) -> o_level 3, pops return 0x041,0x042,0x043.
//  i_rx_done held 5 cycles for 0x55 -> exactly one entry stored, o_level 1.
//  Fill 16 entries, 17th frame with no pop -> o_irq_overrun=1, o_level 16, head still 1st word;
//   repeat with i_rd_ack coincident with PUSH -> accepted, no overrun.
//  i_rts_level=4: o_fifo_full rises on 4th stored entry, falls the cycle after pop to 3.
//  Frame with parity_error=1, frame_error=1: i_parity_enable=1 -> o_rd_data[9:8]=2'b11; =0 -> 2'b10.
//  UART_RX_TIMEOUT_EN, i_bit_length=10, i_timeout_bits=4: one frame then idle -> o_irq_timeout set
//   40 cycles after entering GAP; i_status_clr clears; macro undefined -> stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
package uart_pkg;

   localparam int RX_ENTRY_W = 10;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      PUSH,
      GAP
   } rx_ctrl_state_e;

   typedef struct packed {
      logic       frame_err;
      logic       parity_err;
      logic [7:0] data;
   } rx_fifo_entry_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - receiver-side and read-side handshake bundle of uart_rx_ctrl
interface uart_rx_ctrl_if;
   import uart_pkg::*;

   logic                  i_rx_started;
   logic                  i_rx_done;
   logic                  i_rx_frame_error;
   logic                  i_rx_parity_error;
   logic [8:0]            i_rx_word;
   logic                  o_fifo_full;
   logic                  i_rd_ack;
   logic                  o_rd_valid;
   logic [RX_ENTRY_W-1:0] o_rd_data;

   modport slave (
      input  i_rx_started, i_rx_done, i_rx_frame_error, i_rx_parity_error, i_rx_word, i_rd_ack,
      output o_fifo_full, o_rd_valid, o_rd_data
   );

   modport master (
      output i_rx_started, i_rx_done, i_rx_frame_error, i_rx_parity_error, i_rx_word, i_rd_ack,
      input  o_fifo_full, o_rd_valid, o_rd_data
   );

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word fall-through synchronous FIFO; push while full is
// accepted only when a pop frees a slot in the same cycle
module uart_sync_fifo #(
   parameter  int WIDTH = 10,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_push, do_pop;

   assign full  = (level_q == LW'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      level_d  = level_q + LW'(do_push) - LW'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage carries no reset; rdata is masked while empty instead.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - frame capture sequencer, RX FIFO back-pressure and interrupts behind uart_rx;
// idle-timeout counters are built only when UART_RX_TIMEOUT_EN is defined
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter  int FIFO_DEPTH = 16,
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_nrst,
   uart_rx_ctrl_if.slave    bus,
   input  logic             i_parity_enable,
   input  logic [CNT_W-1:0] i_rts_level,
   input  logic [31:0]      i_bit_length,
   input  logic [7:0]       i_timeout_bits,
   input  logic             i_status_clr,
   output logic [CNT_W-1:0] o_level,
   output logic             o_irq_data,
   output logic             o_irq_overrun,
   output logic             o_irq_timeout
);

   rx_ctrl_state_e   state_q, state_d;
   rx_fifo_entry_t   entry_q, entry_d;
   rx_fifo_entry_t   head;
   logic             done_prev_q;
   logic             fifo_full_q, fifo_full_d;
   logic             overrun_q, overrun_d;
   logic             done_rise, push, pop;
   logic             f_full, f_empty;
   logic [CNT_W-1:0] f_level;

   assign done_rise = bus.i_rx_done && !done_prev_q;
   assign push      = (state_q == PUSH);
   assign pop       = bus.i_rd_ack && !f_empty;

   uart_sync_fifo #(
      .WIDTH (RX_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_nrst),
      .push  (push),
      .pop   (bus.i_rd_ack),
      .wdata (entry_q),
      .rdata (head),
      .full  (f_full),
      .empty (f_empty),
      .level (f_level)
   );

   always_comb begin
      state_d = state_q;
      entry_d = entry_q;
      case (state_q)
         IDLE:   if (bus.i_rx_started) state_d = ACTIVE;
         ACTIVE: begin
            if (done_rise) begin
               state_d            = PUSH;
               entry_d.frame_err  = bus.i_rx_frame_error;
               entry_d.parity_err = bus.i_rx_parity_error && i_parity_enable;
               entry_d.data       = bus.i_rx_word[7:0];
            end
         end
         PUSH:   state_d = GAP;
         GAP: begin
            if (bus.i_rx_started) state_d = ACTIVE;
            else if (f_empty)     state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A zero threshold compares true at any occupancy, so RTS stays asserted.
      fifo_full_d = (f_level >= i_rts_level) || f_full;
      overrun_d   = (push && f_full && !pop) ? 1'b1 : (i_status_clr ? 1'b0 : overrun_q);
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q     <= IDLE;
         entry_q     <= '0;
         done_prev_q <= 1'b0;
         fifo_full_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         entry_q     <= entry_d;
         done_prev_q <= bus.i_rx_done;
         fifo_full_q <= fifo_full_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.o_fifo_full = fifo_full_q;
   assign bus.o_rd_valid  = !f_empty;
   assign bus.o_rd_data   = head;
   assign o_level         = f_level;
   assign o_irq_data      = !f_empty;
   assign o_irq_overrun   = overrun_q;

`ifdef UART_RX_TIMEOUT_EN
   logic [31:0] presc_q, presc_d;
   logic [7:0]  bits_q, bits_d;
   logic        timeout_q, timeout_d;
   logic        to_set;

   always_comb begin
      presc_d = '0;
      bits_d  = '0;
      to_set  = 1'b0;
      // Counting stops once the limit is reached so a cleared flag is not re-armed by the same idle spell.
      if (state_q == GAP && !f_empty && !bus.i_rx_started && !pop && i_timeout_bits != 8'd0) begin
         presc_d = presc_q;
         bits_d  = bits_q;
         if (bits_q < i_timeout_bits) begin
            if (presc_q + 32'd1 >= i_bit_length) begin
               presc_d = '0;
               bits_d  = bits_q + 8'd1;
               to_set  = (bits_q + 8'd1 == i_timeout_bits);
            end else begin
               presc_d = presc_q + 32'd1;
            end
         end
      end
      timeout_d = to_set ? 1'b1 : (i_status_clr ? 1'b0 : timeout_q);
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         presc_q   <= '0;
         bits_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         bits_q    <= bits_d;
         timeout_q <= timeout_d;
      end
   end

   assign o_irq_timeout = timeout_q;

   logic unused_in;
   assign unused_in = bus.i_rx_word[8];
`else
   assign o_irq_timeout = 1'b0;

   logic unused_in;
   assign unused_in = ^{bus.i_rx_word[8], i_bit_length, i_timeout_bits};
`endif

endmodule
